// File: rtl/gpu_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : gpu_regfile_pkg
// Brief    : Shared select indices, CTRL/STAT field positions, FSM encoding
//            and opcodes for the HPS-to-card register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gpu_regfile_pkg;

  localparam int C_SEL_W      = 6;
  localparam int C_SEL_CTRL_H = 0;
  localparam int C_SEL_STAT_C = 1;
  localparam int C_SEL_ADDR_H = 2;
  localparam int C_SEL_DATA_H = 3;
  localparam int C_SEL_DATA_C = 4;
  localparam int C_SEL_RSVD   = 5;

  localparam int C_CTRL_GO     = 0;
  localparam int C_CTRL_OP_LSB = 1;
  localparam int C_CTRL_OP_MSB = 3;
  localparam int C_CTRL_IRQ_EN = 4;
  localparam int C_CTRL_CLR    = 5;

  localparam int C_STAT_BUSY     = 0;
  localparam int C_STAT_DONE     = 1;
  localparam int C_STAT_ERR      = 2;
  localparam int C_STAT_TIMEOUT  = 3;
  localparam int C_STAT_CODE_LSB = 8;
  localparam int C_STAT_CODE_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  localparam logic [2:0] C_OP_NOP   = 3'd0;
  localparam logic [2:0] C_OP_READ  = 3'd1;
  localparam logic [2:0] C_OP_WRITE = 3'd2;
  localparam logic [2:0] C_OP_FILL  = 3'd3;

  // Only a single set bit among the five implemented registers is a legal access.
  function automatic logic sel_is_valid(input logic [C_SEL_W-1:0] s);
    return !s[C_SEL_RSVD] && $onehot(s[4:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/card_cmd_fsm.sv
//------------------------------------------------------------------------------
// Module   : card_cmd_fsm
// Brief    : Command sequencer toward the GPU card: valid/ready issue, response
//            capture, completion irq. Optional timeout under REGFILE_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module card_cmd_fsm
  import gpu_regfile_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef REGFILE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              clr,
  input  logic [2:0]        op_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              irq_en,
  input  logic              cmd_ready,
  input  logic              resp_valid,
  input  logic [7:0]        resp_code,
  input  logic [DATA_W-1:0] resp_data,
  output logic              cmd_valid,
  output logic [2:0]        cmd_op,
  output logic [DATA_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        stat_code,
  output logic [DATA_W-1:0] resp_word,
  output logic              irq
);

  fsm_state_t        r_state;
  logic              r_cmd_valid;
  logic [2:0]        r_cmd_op;
  logic [DATA_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_data;
  logic              r_done;
  logic              r_timeout;
  logic              r_irq;
  logic [7:0]        r_code;
  logic [DATA_W-1:0] r_resp_word;
  logic              w_busy;
  logic              w_expire;

  assign w_busy = (r_state == ST_ISSUE) || (r_state == ST_RESP);

`ifdef REGFILE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Counter sits at zero outside ISSUE/RESP, so every command starts fresh.
  always_ff @(posedge clk) begin
    if (!reset_n || !w_busy) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  assign w_expire = w_busy && (r_cnt == C_CNT_LAST);
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_irq       <= 1'b0;
      r_code      <= '0;
      r_resp_word <= '0;
    end else begin
      if (clr) begin
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
        r_irq     <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            r_cmd_op    <= op_in;
            r_cmd_addr  <= addr_in;
            r_cmd_data  <= data_in;
            r_cmd_valid <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= ST_ISSUE;
          end else if (clr) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_valid && !w_expire) begin
            r_resp_word <= resp_data;
            r_code      <= resp_code;
            r_done      <= 1'b1;
            if (irq_en) r_irq <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Expiry overrides any handshake progress in the same cycle.
      if (w_expire) begin
        r_cmd_valid <= 1'b0;
        r_done      <= 1'b1;
        r_timeout   <= 1'b1;
        if (irq_en) r_irq <= 1'b1;
        r_state     <= ST_DONE;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_data  = r_cmd_data;
  assign busy      = w_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign stat_code = r_code;
  assign resp_word = r_resp_word;
  assign irq       = r_irq;

endmodule

`default_nettype wire

// File: rtl/hps_card_regfile.sv
//------------------------------------------------------------------------------
// Module   : hps_card_regfile
// Brief    : HPS register file (CTRL/STAT/ADDR/DATA/DATA_C) with readback path,
//            driving card_cmd_fsm. Timeout feature under REGFILE_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hps_card_regfile
  import gpu_regfile_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef REGFILE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [C_SEL_W-1:0] sel,
  input  logic               wr,
  input  logic               rd,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  output logic               readdatavalid,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [2:0]         cmd_op,
  output logic [DATA_W-1:0]  cmd_addr,
  output logic [DATA_W-1:0]  cmd_data,
  input  logic               resp_valid,
  input  logic [7:0]         resp_code,
  input  logic [DATA_W-1:0]  resp_data,
  output logic               irq
);

  logic              w_sel_ok;
  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_go;
  logic              w_clr;
  logic              w_busy;
  logic              w_done;
  logic              w_timeout;
  logic [7:0]        w_code;
  logic [DATA_W-1:0] w_data_c;
  logic [DATA_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_stat;
  logic [DATA_W-1:0] w_rd_word;

  logic [2:0]        r_op;
  logic              r_irq_en;
  logic              r_err;
  logic [DATA_W-1:0] r_addr_h;
  logic [DATA_W-1:0] r_data_h;
  logic [DATA_W-1:0] r_readdata;
  logic              r_readdatavalid;

  assign w_sel_ok  = sel_is_valid(sel);
  assign w_wr      = wr && w_sel_ok;
  assign w_ctrl_wr = w_wr && sel[C_SEL_CTRL_H];
  assign w_go      = w_ctrl_wr && writedata[C_CTRL_GO];
  assign w_clr     = w_ctrl_wr && writedata[C_CTRL_CLR];

  always_comb begin
    w_ctrl = '0;
    w_ctrl[C_CTRL_OP_MSB:C_CTRL_OP_LSB] = r_op;
    w_ctrl[C_CTRL_IRQ_EN]               = r_irq_en;

    w_stat = '0;
    w_stat[C_STAT_BUSY]                     = w_busy;
    w_stat[C_STAT_DONE]                     = w_done;
    w_stat[C_STAT_ERR]                      = r_err;
    w_stat[C_STAT_TIMEOUT]                  = w_timeout;
    w_stat[C_STAT_CODE_MSB:C_STAT_CODE_LSB] = w_code;

    w_rd_word = '0;
    if (w_sel_ok) begin
      if      (sel[C_SEL_CTRL_H]) w_rd_word = w_ctrl;
      else if (sel[C_SEL_STAT_C]) w_rd_word = w_stat;
      else if (sel[C_SEL_ADDR_H]) w_rd_word = r_addr_h;
      else if (sel[C_SEL_DATA_H]) w_rd_word = r_data_h;
      else                        w_rd_word = w_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op            <= '0;
      r_irq_en        <= 1'b0;
      r_err           <= 1'b0;
      r_addr_h        <= '0;
      r_data_h        <= '0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_op     <= writedata[C_CTRL_OP_MSB:C_CTRL_OP_LSB];
        r_irq_en <= writedata[C_CTRL_IRQ_EN];
      end
      // Command operands are frozen while a command is in flight.
      if (w_wr && sel[C_SEL_ADDR_H] && !w_busy) r_addr_h <= writedata;
      if (w_wr && sel[C_SEL_DATA_H] && !w_busy) r_data_h <= writedata;
      if (w_clr) r_err <= 1'b0;
      if (w_busy && (w_go || (w_wr && (sel[C_SEL_ADDR_H] || sel[C_SEL_DATA_H]))))
        r_err <= 1'b1;
      r_readdatavalid <= rd;
      r_readdata      <= rd ? w_rd_word : '0;
    end
  end

  card_cmd_fsm #(
    .DATA_W         (DATA_W)
`ifdef REGFILE_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
  ) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (w_go),
    .clr        (w_clr),
    .op_in      (writedata[C_CTRL_OP_MSB:C_CTRL_OP_LSB]),
    .addr_in    (r_addr_h),
    .data_in    (r_data_h),
    .irq_en     (r_irq_en),
    .cmd_ready  (cmd_ready),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .resp_data  (resp_data),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .busy       (w_busy),
    .done       (w_done),
    .timeout    (w_timeout),
    .stat_code  (w_code),
    .resp_word  (w_data_c),
    .irq        (irq)
  );

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule

`default_nettype wire

// File: tb/tb_hps_card_regfile.sv
//------------------------------------------------------------------------------
// Module   : tb_hps_card_regfile
// Brief    : Directed self-checking bench for hps_card_regfile with a read
//            scoreboard. Timeout scenario selected by REGFILE_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hps_card_regfile;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [5:0]        sel = '0;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              resp_valid = 1'b0;
  logic [7:0]        resp_code = '0;
  logic [DATA_W-1:0] resp_data = '0;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic rd_q = 1'b0;

  always #5 clk = ~clk;

  hps_card_regfile #(
    .DATA_W (DATA_W)
`ifdef REGFILE_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sel           (sel),
    .wr            (wr),
    .rd            (rd),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .resp_valid    (resp_valid),
    .resp_code     (resp_code),
    .resp_data     (resp_data),
    .irq           (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [5:0] s, input logic [31:0] d);
    sel = s; writedata = d; wr = 1'b1;
    tick();
    wr = 1'b0; sel = '0; writedata = '0;
  endtask

  task automatic rd_reg(input logic [5:0] s, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    exp_q.push_back(e);
    sel = s; rd = 1'b1;
    tick();
    rd = 1'b0; sel = '0;
    tick();
  endtask

  // Read data must appear exactly one cycle after each rd strobe.
  always @(posedge clk) rd_q <= rd;

  always @(negedge clk) begin
    if (rd_q || readdatavalid) begin
      chk("readdatavalid", {31'd0, readdatavalid}, {31'd0, rd_q});
      if (readdatavalid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk(mon_e.tag, readdata, mon_e.val);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_rdv", {31'd0, readdatavalid}, 32'h0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    chk("rst_cmd_op", {29'd0, cmd_op}, 32'h0);
    chk("rst_cmd_addr", cmd_addr, 32'h0);
    chk("rst_cmd_data", cmd_data, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();

    rd_reg(6'h01, 32'h0, "rst_ctrl");
    rd_reg(6'h02, 32'h0, "rst_stat");
    rd_reg(6'h04, 32'h0, "rst_addr");
    rd_reg(6'h08, 32'h0, "rst_data_h");
    rd_reg(6'h10, 32'h0, "rst_data_c");
    rd_reg(6'h20, 32'h0, "rst_rsvd");
    rd_reg(6'h00, 32'h0, "rst_nosel");
    chk("irq_idle", {31'd0, irq}, 32'h0);

    // Normal command with a 5-cycle ready stall
    wr_reg(6'h04, 32'h0000_1000);
    wr_reg(6'h08, 32'hCAFE_F00D);
    rd_reg(6'h04, 32'h0000_1000, "addr_h_rb");
    rd_reg(6'h08, 32'hCAFE_F00D, "data_h_rb");
    chk("cmd_valid_pre_go", {31'd0, cmd_valid}, 32'h0);
    wr_reg(6'h01, 32'h13);
    chk("cmd_valid_go", {31'd0, cmd_valid}, 32'h1);
    chk("cmd_op_go", {29'd0, cmd_op}, 32'h1);
    chk("cmd_addr_go", cmd_addr, 32'h0000_1000);
    chk("cmd_data_go", cmd_data, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cmd_valid_stall", {31'd0, cmd_valid}, 32'h1);
      chk("cmd_addr_stall", cmd_addr, 32'h0000_1000);
    end
    rd_reg(6'h02, 32'h0000_0001, "stat_issue");
    rd_reg(6'h01, 32'h0000_0012, "ctrl_rb");
    chk("cmd_valid_pre_accept", {31'd0, cmd_valid}, 32'h1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("cmd_valid_accept", {31'd0, cmd_valid}, 32'h0);
    rd_reg(6'h02, 32'h0000_0001, "stat_resp");
    chk("irq_pre_resp", {31'd0, irq}, 32'h0);
    resp_valid = 1'b1; resp_code = 8'h5A; resp_data = 32'h1234_5678;
    tick();
    resp_valid = 1'b0; resp_code = '0; resp_data = '0;
    chk("irq_done", {31'd0, irq}, 32'h1);
    rd_reg(6'h02, 32'h0000_5A02, "stat_done");
    rd_reg(6'h10, 32'h1234_5678, "data_c_done");

    // Busy-time errors, then CLR
    wr_reg(6'h01, 32'h15);
    chk("cmd_op_go2", {29'd0, cmd_op}, 32'h2);
    chk("irq_kept", {31'd0, irq}, 32'h1);
    wr_reg(6'h01, 32'h1F);
    chk("cmd_op_busy_go", {29'd0, cmd_op}, 32'h2);
    wr_reg(6'h04, 32'hDEAD_0000);
    chk("cmd_addr_busy", cmd_addr, 32'h0000_1000);
    rd_reg(6'h04, 32'h0000_1000, "addr_h_busy");
    rd_reg(6'h02, 32'h0000_5A05, "stat_err_busy");
    rd_reg(6'h01, 32'h0000_001E, "ctrl_busy");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    resp_valid = 1'b1; resp_code = 8'h33; resp_data = 32'hA5A5_A5A5;
    tick();
    resp_valid = 1'b0; resp_code = '0; resp_data = '0;
    rd_reg(6'h02, 32'h0000_3306, "stat_done_err");
    rd_reg(6'h10, 32'hA5A5_A5A5, "data_c_2");
    wr_reg(6'h01, 32'h20);
    chk("irq_clr", {31'd0, irq}, 32'h0);
    rd_reg(6'h02, 32'h0000_3300, "stat_clr");
    rd_reg(6'h01, 32'h0, "ctrl_clr");

    // Illegal selects
    wr_reg(6'h11, 32'hFFFF_FFFF);
    wr_reg(6'h20, 32'hFFFF_FFFF);
    chk("cmd_valid_badsel", {31'd0, cmd_valid}, 32'h0);
    rd_reg(6'h11, 32'h0, "rd_multihot");
    rd_reg(6'h20, 32'h0, "rd_rsvd");
    rd_reg(6'h04, 32'h0000_1000, "addr_badsel");
    rd_reg(6'h08, 32'hCAFE_F00D, "data_h_badsel");
    rd_reg(6'h01, 32'h0, "ctrl_badsel");
    rd_reg(6'h02, 32'h0000_3300, "stat_badsel");

    // Stray responses, then reset during RESP
    resp_valid = 1'b1; resp_code = 8'h77; resp_data = 32'h1111_1111;
    tick();
    resp_valid = 1'b0;
    rd_reg(6'h02, 32'h0000_3300, "stat_idle_resp");
    rd_reg(6'h10, 32'hA5A5_A5A5, "data_c_idle_resp");
    wr_reg(6'h01, 32'h13);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0; resp_code = '0; resp_data = '0;
    chk("cmd_valid_issue_resp", {31'd0, cmd_valid}, 32'h1);
    rd_reg(6'h02, 32'h0000_3301, "stat_issue_resp");
    rd_reg(6'h10, 32'hA5A5_A5A5, "data_c_issue_resp");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("rst2_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    chk("rst2_cmd_op", {29'd0, cmd_op}, 32'h0);
    chk("rst2_cmd_addr", cmd_addr, 32'h0);
    chk("rst2_cmd_data", cmd_data, 32'h0);
    chk("rst2_irq", {31'd0, irq}, 32'h0);
    chk("rst2_rdv", {31'd0, readdatavalid}, 32'h0);
    reset_n = 1'b1;
    tick();
    rd_reg(6'h02, 32'h0, "rst2_stat");
    rd_reg(6'h04, 32'h0, "rst2_addr");
    rd_reg(6'h10, 32'h0, "rst2_data_c");

    // Card never accepts
    wr_reg(6'h01, 32'h01);
    chk("cmd_valid_stuck", {31'd0, cmd_valid}, 32'h1);
`ifdef REGFILE_TIMEOUT_EN
    repeat (15) tick();
    chk("cmd_valid_pre_timeout", {31'd0, cmd_valid}, 32'h1);
    tick();
    chk("cmd_valid_timeout", {31'd0, cmd_valid}, 32'h0);
    rd_reg(6'h02, 32'h0000_000A, "stat_timeout");
    rd_reg(6'h10, 32'h0, "data_c_timeout");
    chk("irq_timeout", {31'd0, irq}, 32'h0);
`else
    repeat (10000) tick();
    chk("cmd_valid_wait", {31'd0, cmd_valid}, 32'h1);
    rd_reg(6'h02, 32'h0000_0001, "stat_wait");
`endif

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hps_card_regfile.md
Name: hps_card_regfile

Overview:
- Register file and command sequencer downstream of address_decoder.
- Consumes the one-hot select vector produced from the QSYS 3-bit address, plus HPS read/write strobes.
- Holds the HPS-written control, address and data registers, and the card-written status and response-data registers.
- Runs a valid/ready command handshake toward the GPU card and captures the card's response.

Parameters:
- DATA_W, 32, width of HPS data bus and all registers.
- TIMEOUT_CYCLES, 1024, cycles allowed in ISSUE+RESP before timeout (only with REGFILE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  synchronous active-low reset.
- sel  in  6  one-hot register select from address_decoder; bit0 CTRL_H, bit1 STAT_C, bit2 ADDR_H, bit3 DATA_H, bit4 DATA_C, bit5 reserved.
- wr  in  1  HPS write strobe.
- rd  in  1  HPS read strobe.
- writedata  in  DATA_W  HPS write data.
- readdata  out  DATA_W  HPS read data.
- readdatavalid  out  1  one-cycle pulse qualifying readdata.
- cmd_valid  out  1  command valid to card.
- cmd_ready  in  1  card accepts command.
- cmd_op  out  3  opcode.
- cmd_addr  out  DATA_W  command address.
- cmd_data  out  DATA_W  command data.
- resp_valid  in  1  card response strobe.
- resp_code  in  8  card status code.
- resp_data  in  DATA_W  card response data.
- irq  out  1  level interrupt to HPS.

Behaviour:
- Clock and reset: one clock (clk); reset_n is synchronous, active-low.
- Reset values: all registers 0, readdata 0, readdatavalid 0, cmd_valid 0, cmd_* 0, irq 0, state IDLE. Reset mid-handshake drops cmd_valid in the next cycle with no completion.
- Valid select: sel exactly one-hot within bits[4:0]. Zero, multi-hot (e.g. 6'h11) or bit5 selects:
  - writes are ignored;
  - reads return 0 with readdatavalid still asserted (no bus hang).
- Writes: take effect at the clk edge where wr=1. STAT_C and DATA_C are read-only to HPS; writes to them are ignored.
  - ADDR_H/DATA_H writes while busy are ignored and set STAT.err.
- CTRL_H bit fields:
  - [0] GO, self-clearing, reads 0.
  - [3:1] op.
  - [4] irq_en.
  - [5] CLR, self-clearing: clears done, err, timeout and irq; DONE goes to IDLE.
  - CLR and GO in the same write: CLR applies first, then GO.
- Reads: rd=1 gives readdatavalid=1 on the next cycle, with readdata = register value before that edge. rd and wr in the same cycle return the pre-write value.
- STAT_C bit fields:
  - [0] busy (ISSUE or RESP);
  - [1] done;
  - [2] err;
  - [3] timeout;
  - [15:8] resp_code;
  - remaining bits 0.
- FSM states: IDLE, ISSUE, RESP, DONE.
  - IDLE/DONE + GO: latch ADDR_H, DATA_H and op into cmd_addr, cmd_data, cmd_op; clear done; go to ISSUE. cmd_valid=1 on the cycle after the write.
  - ISSUE: hold cmd_valid and cmd_* stable until cmd_ready=1 is sampled; that edge drops cmd_valid and goes to RESP. If cmd_ready is already high on entry, the handshake completes in 1 cycle.
  - RESP: on resp_valid=1, capture resp_data into DATA_C and resp_code into STAT[15:8]; set done; set irq if irq_en; go to DONE.
  - DONE: hold until CLR or GO.
  - GO in ISSUE/RESP: ignored, sets err.
  - resp_valid outside RESP: ignored.
- irq: set only on completion, cleared only by CLR or reset. Clearing irq_en does not clear a pending irq.

Optional Feature:
- Macro: REGFILE_TIMEOUT_EN.
- With it: a counter runs in ISSUE and RESP and clears on entry to ISSUE. On reaching TIMEOUT_CYCLES:
  - cmd_valid drops;
  - go to DONE with done=1 and timeout=1;
  - irq per irq_en;
  - DATA_C unchanged.
- Without it: no counter logic; the FSM waits indefinitely; STAT[3] reads 0.

Decomposition:
- Shared package gpu_regfile_pkg holds:
  - select bit indices;
  - CTRL/STAT bit positions;
  - FSM state encoding;
  - opcode constants.
- One natural sub-module: card_cmd_fsm, containing the state machine, cmd handshake and timeout counter. The register/readback logic stays in the top.

Test Plan:
- Reset, then read every select -> all readdata 0, readdatavalid one cycle after each rd, irq 0.
- Write ADDR_H=0x1000, DATA_H=0xCAFEF00D, CTRL_H=0x13 (GO, op=1, irq_en); hold cmd_ready low 5 cycles, then high -> cmd_valid high from cycle+1 and stable; drops after accept. Then resp_valid with code 0x5A and data 0x12345678 -> STAT reads 0x5A02, DATA_C reads 0x12345678, irq=1.
- GO while busy, and ADDR_H write while busy -> STAT.err=1, cmd_* unchanged, ADDR_H unchanged; CTRL write 0x20 -> err, done and irq clear.
- sel=6'h11 write 0xFFFFFFFF, then read -> no register changes, readdata 0, readdatavalid 1.
- resp_valid pulsed in IDLE and ISSUE -> ignored; reset_n low during RESP -> next cycle all outputs at reset values.
- With REGFILE_TIMEOUT_EN, TIMEOUT_CYCLES=16, cmd_ready held low -> after 16 cycles cmd_valid=0, STAT=0x000A (done + timeout); without the macro, still busy after 10000 cycles.
